// File: rtl/fc_mac_accumulator.sv
// FC-layer dot-product engine: streams LANES int8 act/wgt pairs per beat,
// accumulates one neuron, adds its bias and emits a tagged 32-bit result.
module fc_mac_accumulator #(
  parameter int LANES = 4,
  parameter int CNT_W = 10
) (
  input  logic               clk,
  input  logic               srstn,
  input  logic               start,
  input  logic               fc_state_in,
  input  logic [CNT_W-1:0]   in_len,
  input  logic [31:0]        bias,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] act,
  input  logic [8*LANES-1:0] wgt,
  output logic               busy,
  output logic               acc_valid,
  output logic [31:0]        acc_data,
  output logic               fc_state_out
);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state and count, never on in_valid.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [31:0]        bias_q, bias_d;
  logic               fc_state_q, fc_state_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        p_sum_q, p_sum_d;
  logic               p_vld_q, p_vld_d;
  logic [31:0]        acc_data_q, acc_data_d;
  logic signed [15:0] prod [LANES];

  // Product stage: lane products are exact in 16 bits, summed at full width.
  always_comb begin
    p_sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i] = 16'($signed(act[8*i +: 8])) * 16'($signed(wgt[8*i +: 8]));
      p_sum_d = p_sum_d + {{16{prod[i][15]}}, prod[i]};
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    len_d      = len_q;
    bias_d     = bias_q;
    fc_state_d = fc_state_q;
    acc_d      = p_vld_q ? (acc_q + p_sum_q) : acc_q;
    p_vld_d    = 1'b0;
    acc_data_d = acc_data_q;
    in_ready   = 1'b0;
    acc_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = in_len;
          bias_d     = bias;
          fc_state_d = fc_state_in;
          count_d    = '0;
          acc_d      = '0;
          state_d    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        in_ready = (count_q != len_q);
        if (count_q == len_q) begin
          state_d = S_DRAIN;
        end else if (in_valid) begin
          count_d = count_q + CNT_W'(1);
          p_vld_d = 1'b1;
          if (count_d == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last product lands in acc one cycle after it is registered.
        if (!p_vld_q) begin
          acc_data_d = acc_q + bias_q;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        acc_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      len_q      <= '0;
      bias_q     <= '0;
      fc_state_q <= 1'b0;
      acc_q      <= '0;
      p_sum_q    <= '0;
      p_vld_q    <= 1'b0;
      acc_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      len_q      <= len_d;
      bias_q     <= bias_d;
      fc_state_q <= fc_state_d;
      acc_q      <= acc_d;
      p_vld_q    <= p_vld_d;
      acc_data_q <= acc_data_d;
      if (p_vld_d) p_sum_q <= p_sum_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign acc_data     = acc_data_q;
  assign fc_state_out = fc_state_q;

endmodule

// File: tb/tb_fc_mac_accumulator.sv
// Randomized bench for fc_mac_accumulator; expected results come from a
// plain-arithmetic dot-product model and a scoreboard queue.
module tb_fc_mac_accumulator;
  localparam int LANES = 4;
  localparam int CNT_W = 10;
  localparam int W     = 8 * LANES;

  logic             clk;
  logic             srstn;
  logic             start;
  logic             fc_state_in;
  logic [CNT_W-1:0] in_len;
  logic [31:0]      bias;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     act;
  logic [W-1:0]     wgt;
  logic             busy;
  logic             acc_valid;
  logic [31:0]      acc_data;
  logic             fc_state_out;

  fc_mac_accumulator #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .srstn(srstn), .start(start), .fc_state_in(fc_state_in),
    .in_len(in_len), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
    .act(act), .wgt(wgt), .busy(busy), .acc_valid(acc_valid),
    .acc_data(acc_data), .fc_state_out(fc_state_out)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scoreboard state
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [31:0]  exp_q[$];
  logic         exp_tag_q[$];
  logic [W-1:0] beat_a[$];
  logic [W-1:0] beat_w[$];
  int           gap_q[$];
  int           ref_cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int dot(input logic [W-1:0] a, input logic [W-1:0] w);
    int s = 0;
    for (int i = 0; i < LANES; i++)
      s += int'($signed(a[8*i +: 8])) * int'($signed(w[8*i +: 8]));
    return s;
  endfunction

  function automatic logic [W-1:0] splat(input logic [7:0] v);
    return {LANES{v}};
  endfunction

  task automatic push_beat(input logic [W-1:0] a, input logic [W-1:0] w);
    beat_a.push_back(a);
    beat_w.push_back(w);
  endtask

  // Driver: start a neuron from IDLE; model result goes to the scoreboard.
  task automatic start_neuron(input logic tag, input int len, input logic [31:0] b);
    logic [31:0] s;
    s = b;
    for (int i = 0; i < len; i++) s = s + 32'(dot(beat_a[i], beat_w[i]));
    exp_q.push_back(s);
    exp_tag_q.push_back(tag);
    start = 1'b1; fc_state_in = tag; in_len = CNT_W'(len); bias = b;
    @(negedge clk);
    ref_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    fc_state_in = 1'($urandom); in_len = CNT_W'($urandom); bias = $urandom;
    @(negedge clk);
    check_val("busy_after_start", busy, 1);
    check_val("in_ready_after_start", in_ready, (len > 0) ? 1 : 0);
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] w, input int gap);
    bit done = 0;
    repeat (gap) begin
      in_valid = 1'b0; act = W'($urandom); wgt = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; act = a; wgt = w;
    for (int t = 0; t <= 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ref_cyc = cyc;
        done = 1;
      end else if (t == 50) begin
        check_val("beat_accept_timeout", 0, 1);
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for the result pulse and checks data, tag, latency and pulse width.
  task automatic wait_result();
    bit seen = 0;
    logic [31:0] e;
    logic tg;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (acc_valid) begin
        seen = 1;
      end else begin
        check_val("in_ready_after_last", in_ready, 0);
        @(posedge clk); #1;
      end
    end
    check_val("acc_valid_seen", seen, 1);
    e  = exp_q.pop_front();
    tg = exp_tag_q.pop_front();
    if (seen) begin
      check_val("acc_data", acc_data, e);
      check_val("fc_state_out", fc_state_out, tg);
      check_val("latency", cyc - ref_cyc, 3);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("acc_valid_pulse", acc_valid, 0);
      check_val("busy_idle", busy, 0);
      check_val("acc_data_hold", acc_data, e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_neuron(input logic tag, input logic [31:0] b, input int maxgap, input bit junk);
    int len;
    int g;
    len = beat_a.size();
    start_neuron(tag, len, b);
    for (int i = 0; i < len; i++) begin
      g = (gap_q.size() > 0) ? gap_q.pop_front() : $urandom_range(0, maxgap);
      send_beat(beat_a[i], beat_w[i], g);
    end
    if (junk) begin
      in_valid = 1'b1; act = W'($urandom); wgt = W'($urandom);
    end
    wait_result();
    beat_a.delete();
    beat_w.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    srstn = 1'b0; start = 1'b0; fc_state_in = 1'b0; in_len = '0; bias = '0;
    in_valid = 1'b0; act = '0; wgt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_acc_valid", acc_valid, 0);
    check_val("rst_acc_data", acc_data, 0);
    check_val("rst_fc_state_out", fc_state_out, 0);
    @(posedge clk); #1;
    srstn = 1'b1;
    @(posedge clk); #1;

    // Basic sum: 10 - 8 + 100 = 102
    push_beat(32'h04030201, splat(8'd1));
    push_beat(splat(8'hFF), splat(8'd2));
    run_neuron(1'b1, 32'd100, 0, 0);
    check_val("basic_model_102", exp_q.size(), 0);

    // Same data with 3 bubble cycles, plus held in_valid after the last beat
    g0 = $urandom_range(0, 3);
    gap_q.push_back(g0);
    gap_q.push_back(3 - g0);
    push_beat(32'h04030201, splat(8'd1));
    push_beat(splat(8'hFF), splat(8'd2));
    run_neuron(1'b0, 32'd100, 0, 1);

    // Empty neuron
    run_neuron(1'b1, 32'hFFFFFFFB, 0, 0);

    // Extreme operands
    push_beat(splat(8'h80), splat(8'h80));
    run_neuron(1'b0, 32'd0, 0, 0);
    push_beat(splat(8'h80), splat(8'h7F));
    run_neuron(1'b1, 32'd0, 0, 0);

    // Wrap without saturation
    push_beat(32'h00000001, 32'h00000001);
    run_neuron(1'b0, 32'h7FFFFFFF, 0, 0);

    // start during ACCUM must not restart or re-latch
    push_beat(W'($urandom), W'($urandom));
    push_beat(W'($urandom), W'($urandom));
    push_beat(W'($urandom), W'($urandom));
    start_neuron(1'b1, 3, 32'd7);
    send_beat(beat_a[0], beat_w[0], 0);
    start = 1'b1; fc_state_in = 1'b0; in_len = CNT_W'(1); bias = 32'd12345;
    send_beat(beat_a[1], beat_w[1], 1);
    start = 1'b0;
    send_beat(beat_a[2], beat_w[2], 0);
    wait_result();
    beat_a.delete(); beat_w.delete();

    // Reset mid-ACCUM aborts the neuron
    for (int i = 0; i < 4; i++) push_beat(W'($urandom), W'($urandom));
    start_neuron(1'b1, 4, 32'd99);
    send_beat(beat_a[0], beat_w[0], 0);
    void'(exp_q.pop_front());
    void'(exp_tag_q.pop_front());
    beat_a.delete(); beat_w.delete();
    srstn = 1'b0;
    @(posedge clk); #1;
    srstn = 1'b1;
    @(negedge clk);
    check_val("midrst_in_ready", in_ready, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_acc_valid", acc_valid, 0);
    check_val("midrst_acc_data", acc_data, 0);
    check_val("midrst_fc_state_out", fc_state_out, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("midrst_no_valid", acc_valid, 0);
    end
    @(posedge clk); #1;
    push_beat(splat(8'd1), splat(8'd1));
    run_neuron(1'b1, 32'd0, 0, 0);

    // Randomized neurons
    for (int n = 0; n < 25; n++) begin
      int len;
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) push_beat(W'($urandom), W'($urandom));
      run_neuron(1'($urandom), $urandom, 2, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
